// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package md_pkg;

  typedef enum logic [2:0] {
    MD_NOP  = 3'd0,
    MD_MTHI = 3'd1,
    MD_MTLO = 3'd2,
    MD_MUL  = 3'd3,
    MD_DIV  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL     = 2'd1,
    DIV_RUN = 2'd2,
    DIV_FIX = 2'd3
  } md_state_e;

  localparam int DIV_ITERS = 32;
  localparam int DIV_LAT   = 33;

endpackage

// File: rtl/md_div_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step, no sign handling.
module md_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] dsr;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    fits    = shifted >= {1'b0, dsr};
    diff    = shifted[XLEN-1:0] - dsr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= {quo[XLEN-2:0], fits};
      rem <= fits ? diff : shifted[XLEN-1:0];
    end
  end

endmodule

// File: rtl/md_sched.sv
// EX-stage multiply/divide sequencer: accepts MD ops, owns HI/LO, raises stall on hazards.
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic            is_sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            rd_hilo,
  input  logic            flush,
  output logic            op_ready,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int DCW = $clog2(DIV_LAT);

  md_state_e       state_q, state_d;
  logic [MCW-1:0]  mul_cnt;
  logic [DCW-1:0]  div_cnt;
  logic [XLEN-1:0] opa, opb;
  logic            sgn;

  logic            op_md, acc, mul_fin, div_fin, div_step, div_start;
  logic [XLEN-1:0] mag_a, mag_b, quo, rem, quo_s, rem_s;
  logic [2*XLEN-1:0] ext_a, ext_b, prod;
  logic            q_neg, r_neg, b_zero;

  assign op_md    = op_valid && (op >= 3'(MD_MTHI)) && (op <= 3'(MD_DIV));
  assign acc      = op_md && (state_q == IDLE) && !flush;
  assign op_ready = acc;
  assign stall    = !flush && ((op_md && !acc) || (rd_hilo && busy));
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    mul_fin  = 1'b0;
    div_fin  = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && op == 3'(MD_MUL)) state_d = MUL;
        if (acc && op == 3'(MD_DIV)) state_d = DIV_RUN;
      end
      MUL: begin
        if (mul_cnt == '0) begin
          mul_fin = 1'b1;
          state_d = IDLE;
        end
      end
      DIV_RUN: begin
        div_step = 1'b1;
        if (div_cnt == DCW'(DIV_ITERS - 1)) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        div_fin = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flush cancels whatever is in flight, including a completion on this edge
    if (flush) begin
      state_d  = IDLE;
      mul_fin  = 1'b0;
      div_fin  = 1'b0;
      div_step = 1'b0;
    end
  end

  // full-width product of the latched operands; low 2*XLEN bits are the signed result too
  always_comb begin
    ext_a = sgn ? {{XLEN{opa[XLEN-1]}}, opa} : {{XLEN{1'b0}}, opa};
    ext_b = sgn ? {{XLEN{opb[XLEN-1]}}, opb} : {{XLEN{1'b0}}, opb};
    prod  = ext_a * ext_b;
  end

  assign div_start = acc && (op == 3'(MD_DIV));
  assign mag_a     = (is_sign && a[XLEN-1]) ? -a : a;
  assign mag_b     = (is_sign && b[XLEN-1]) ? -b : b;

  md_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .step     (div_step),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo      (quo),
    .rem      (rem)
  );

  // quotient truncates toward zero, remainder follows the dividend
  assign q_neg  = sgn && (opa[XLEN-1] ^ opb[XLEN-1]);
  assign r_neg  = sgn && opa[XLEN-1];
  assign quo_s  = q_neg ? -quo : quo;
  assign rem_s  = r_neg ? -rem : rem;
  assign b_zero = (opb == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mul_cnt <= '0;
      div_cnt <= '0;
      opa     <= '0;
      opb     <= '0;
      sgn     <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= mul_fin || div_fin;
      if (acc) begin
        case (op)
          3'(MD_MTHI): hi <= a;
          3'(MD_MTLO): lo <= a;
          default: begin
            opa     <= a;
            opb     <= b;
            sgn     <= is_sign;
            mul_cnt <= MCW'(MUL_LAT - 1);
            div_cnt <= '0;
          end
        endcase
      end
      if (state_q == MUL && mul_cnt != '0) mul_cnt <= mul_cnt - 1'b1;
      if (div_step) div_cnt <= div_cnt + 1'b1;
      if (mul_fin) {hi, lo} <= prod;
      if (div_fin) begin
        // divide by zero bypasses the sign fixup: all-ones quotient, raw dividend remainder
        lo <= b_zero ? '1  : quo_s;
        hi <= b_zero ? opa : rem_s;
      end
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO and completion cycle queued at accept, checked on done.
module tb_md_sched;
  import md_pkg::*;

  localparam int MUL_LAT = 3;
  localparam int XLEN    = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            op_valid, is_sign, rd_hilo, flush;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b;
  logic            op_ready, stall, busy, done;
  logic [XLEN-1:0] hi, lo;

  md_sched #(.MUL_LAT(MUL_LAT), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .is_sign(is_sign),
    .a(a), .b(b), .rd_hilo(rd_hilo), .flush(flush), .op_ready(op_ready),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic busy_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rst_n && done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
        chk({e.tag, "_lat"}, cyc, e.due);
      end
    end
  end

  // called just after a rising edge; returns just after the accept edge
  task automatic issue(input logic [2:0] o, input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat, input string tag);
    exp_t e;
    op_valid = 1'b1; op = o; is_sign = s; a = av; b = bv;
    @(negedge clk);
    chk({tag, "_rdy"}, op_ready, 1);
    @(posedge clk); #1;
    if (lat > 0) begin
      e.tag = tag; e.hi = ehi; e.lo = elo; e.due = cyc + lat;
      sb.push_back(e);
    end
    op_valid = 1'b0; op = 3'd0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk({tag, "_drain"}, sb.size(), 0);
  endtask

  function automatic void model(input logic [2:0] o, input logic s, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] h, output logic [31:0] l);
    longint p;
    int sx, sy;
    sx = $signed(x); sy = $signed(y);
    if (o == 3'(MD_MUL)) begin
      if (s) p = longint'(sx) * longint'(sy);
      else   p = longint'({32'b0, x}) * longint'({32'b0, y});
      {h, l} = p;
    end else if (s) begin
      l = sx / sy;
      h = sx % sy;
    end else begin
      l = x / y;
      h = x % y;
    end
  endfunction

  initial begin
    logic [31:0] rh, rl, ra, rb;
    logic [2:0]  ro;
    logic        rs;
    logic        stall_bad, got_done;

    rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; is_sign = 1'b0;
    a = '0; b = '0; rd_hilo = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // NOP and undefined op codes neither accept nor stall
    op_valid = 1'b1; op = 3'd0;
    @(negedge clk);
    chk("nop_rdy", op_ready, 0);
    chk("nop_stall", stall, 0);
    @(posedge clk); #1;
    op = 3'd6;
    @(negedge clk);
    chk("op6_stall", {op_ready, stall}, 0);
    @(posedge clk); #1;
    op_valid = 1'b0;

    busy_seen = 1'b0;
    issue(3'(MD_MTHI), 1'b0, 32'h12345678, 0, 0, 0, 0, "mthi");
    chk("mthi_hi", hi, 32'h12345678);
    issue(3'(MD_MTLO), 1'b0, 32'h9ABCDEF0, 0, 0, 0, 0, "mtlo");
    chk("mtlo_hi", hi, 32'h12345678);
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mt_busy", busy_seen, 0);
    chk("mt_done", done, 0);

    issue(3'(MD_MUL), 1'b0, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFE, MUL_LAT, "mulu");
    chk("mulu_busy", busy, 1);
    drain("mulu");
    issue(3'(MD_MUL), 1'b1, -32'sd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT, "muls");
    drain("muls");
    issue(3'(MD_DIV), 1'b1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "divs");
    drain("divs");
    issue(3'(MD_DIV), 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 33, "divu");
    drain("divu");
    issue(3'(MD_DIV), 1'b0, 32'h55, 32'd0, 32'h55, 32'hFFFFFFFF, 33, "dz_u");
    drain("dz_u");
    issue(3'(MD_DIV), 1'b1, 32'h80000005, 32'd0, 32'h80000005, 32'hFFFFFFFF, 33, "dz_s");
    drain("dz_s");
    issue(3'(MD_DIV), 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, "ovf");
    drain("ovf");

    // structural + HI/LO read hazard while a divide runs; MTLO accepted in the done cycle
    issue(3'(MD_DIV), 1'b0, 32'd1000, 32'd10, 32'd0, 32'd100, 33, "hz_div");
    repeat (4) @(posedge clk);
    #1;
    op_valid = 1'b1; op = 3'(MD_MTLO); a = 32'hCAFE;
    @(posedge clk); #1;
    rd_hilo = 1'b1;
    stall_bad = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        chk("hz_done_stall", stall, 0);
        chk("hz_done_rdy", op_ready, 1);
        break;
      end else if (!stall || op_ready) stall_bad = 1'b1;
    end
    chk("hz_got_done", got_done, 1);
    chk("hz_stall_held", stall_bad, 0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'd0; rd_hilo = 1'b0;
    chk("hz_mtlo_lo", lo, 32'hCAFE);
    chk("hz_hi", hi, 32'h0);

    // flush mid-divide, with a MULT presented in the flush cycle
    issue(3'(MD_MTHI), 1'b0, 32'hAAAA, 0, 0, 0, 0, "pre_hi");
    issue(3'(MD_MTLO), 1'b0, 32'hBBBB, 0, 0, 0, 0, "pre_lo");
    issue(3'(MD_DIV), 1'b0, 32'd1000, 32'd3, 0, 0, 0, "fl_div");
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; op_valid = 1'b1; op = 3'(MD_MUL); rd_hilo = 1'b1;
    @(negedge clk);
    chk("fl_rdy", op_ready, 0);
    chk("fl_stall", stall, 0);
    @(posedge clk); #1;
    flush = 1'b0; op_valid = 1'b0; op = 3'd0; rd_hilo = 1'b0;
    chk("fl_busy", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    chk("fl_hi", hi, 32'hAAAA);
    chk("fl_lo", lo, 32'hBBBB);

    // flush landing on the MULT completion edge
    issue(3'(MD_MUL), 1'b0, 32'd5, 32'd7, 0, 0, 0, "flc");
    repeat (MUL_LAT - 1) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flc_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("flc_hilo", {hi, lo}, {32'hAAAA, 32'hBBBB});

    // reset in the middle of a MULT
    issue(3'(MD_MUL), 1'b0, 32'd5, 32'd7, 0, 0, 0, "rstm");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstm_hilo", {hi, lo}, 64'h0);
    chk("rstm_busy", {busy, done}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rstm_hilo2", {hi, lo}, 64'h0);

    for (int i = 0; i < 8; i++) begin
      ro = ($urandom_range(0, 1) == 0) ? 3'(MD_MUL) : 3'(MD_DIV);
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb = rb >> $urandom_range(8, 28);
      if (rb == 0) rb = 32'd9;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      model(ro, rs, ra, rb, rh, rl);
      issue(ro, rs, ra, rb, rh, rl, (ro == 3'(MD_MUL)) ? MUL_LAT : 33, "rnd");
      drain("rnd");
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_sb", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
